// File: rtl/instr_pkg.sv
// instr_pkg: opcodes, operation selects, widths and FIFO entry layout shared by the encoder and the datapath decoder
package instr_pkg;
  localparam int INSTR_W = 32;
  localparam int DATA_W = 8;
  localparam logic [7:0] OPC_ADD = 8'h88;
  localparam logic [7:0] OPC_SUB = 8'h89;
  localparam logic [7:0] OPC_INC = 8'h8A;
  typedef enum logic [1:0] {SEL_ADD = 2'b00, SEL_SUB = 2'b01, SEL_INC = 2'b10, SEL_ILL = 2'b11} op_sel_e;
  typedef struct packed {
    logic [DATA_W-1:0] exp;
    logic [INSTR_W-1:0] word;
  } entry_t;
  localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request handshake (req_*) in and instruction handshake (ins_*) out; master = requester/consumer, slave = encoder
interface instr_encoder_if;
  import instr_pkg::*;
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic ins_valid;
  logic ins_ready;
  logic [INSTR_W-1:0] ins_word;
  logic [DATA_W-1:0] ins_exp;
  modport master(output req_valid, req_op, req_a, req_b, ins_ready, input req_ready, ins_valid, ins_word, ins_exp);
  modport slave(input req_valid, req_op, req_a, req_b, ins_ready, output req_ready, ins_valid, ins_word, ins_exp);
endinterface

// File: rtl/instr_fifo.sv
// instr_fifo: synchronous FIFO; ports clk, rst, push_i/pop_i, wdata_i, rdata_o (head), count_o, full_o, empty_o
module instr_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign cnt_d = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  // count never exceeds DEPTH (a power of two), so its top bit alone means full
  assign full_o = cnt_q[AW];
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(do_push);
      rptr_q <= rptr_q + AW'(do_pop);
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes ADD/SUB/INC requests into 32-bit words with expected results and issues them in order; ports clk, rst, bus (slave), fifo_count, issued_cnt, illegal_cnt, illegal_pulse
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_encoder_if.slave         bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [CNT_W-1:0]       issued_cnt,
  output logic [7:0]             illegal_cnt,
  output logic                   illegal_pulse
);
  entry_t enc, head;
  logic full, empty, legal, accept, issue;
  logic [CNT_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [7:0] illegal_cnt_q, illegal_cnt_d;
  logic illegal_pulse_q, illegal_pulse_d;
  always_comb begin
    enc.word = {bus.req_op == SEL_SUB ? OPC_SUB : bus.req_op == SEL_INC ? OPC_INC : OPC_ADD,
                8'h00, bus.req_op == SEL_INC ? 8'h00 : bus.req_b, bus.req_a};
    enc.exp = bus.req_op == SEL_SUB ? bus.req_a - bus.req_b :
              bus.req_op == SEL_INC ? bus.req_a + 8'd1 : bus.req_a + bus.req_b;
  end
  assign legal = bus.req_op != SEL_ILL;
  assign accept = bus.req_valid && bus.req_ready;
  assign issue = bus.ins_valid && bus.ins_ready;
  // ready comes from the registered count only, so a pop never frees a slot in the same cycle
  assign bus.req_ready = !full;
  assign bus.ins_valid = !empty;
  assign bus.ins_word = empty ? '0 : head.word;
  assign bus.ins_exp = empty ? '0 : head.exp;
  instr_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_i(accept && legal), .pop_i(issue), .wdata_i(enc),
    .rdata_o(head), .count_o(fifo_count), .full_o(full), .empty_o(empty)
  );
  assign issued_cnt_d = issued_cnt_q + CNT_W'(issue);
  assign illegal_pulse_d = accept && !legal;
  assign illegal_cnt_d = illegal_cnt_q + 8'(illegal_pulse_d && illegal_cnt_q != 8'hFF);
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_q <= '0;
      illegal_cnt_q <= '0;
      illegal_pulse_q <= 1'b0;
    end else begin
      issued_cnt_q <= issued_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
      illegal_pulse_q <= illegal_pulse_d;
    end
  end
  assign issued_cnt = issued_cnt_q;
  assign illegal_cnt = illegal_cnt_q;
  assign illegal_pulse = illegal_pulse_q;
endmodule
